// File: rtl/ucpu_control_unit.sv
// Micro-CPU instruction sequencer with accumulator datapath.
// Drives a two-phase data memory interface and an OUT valid/ready port.
//
// state  | meaning
// FETCH  | instr_ready high, waiting for an instruction byte
// DEC    | decode; NOP/LDI/illegal-address complete here
// EXEC1  | memory phase 1 (control_state=EXECUTE1, enable high)
// EXEC2  | memory phase 2; store lands at the exit edge
// WB     | read data consumed by LD/ADD/SUB/AND
// OUTW   | out_valid high until out_ready
module ucpu_control_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int DEPTH          = 16,
  parameter int CONTROL_STATES = 3,
  parameter int DECODE         = 0,
  parameter int EXECUTE1       = 1,
  parameter int EXECUTE2       = 2,
  parameter int REG_FILE_READ  = 0,
  parameter int REG_FILE_WRITE = 1
) (
  input  logic                                sys_clk,
  input  logic                                sys_reset,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [ADDR_WIDTH+2:0]               instr,
  output logic [$clog2(CONTROL_STATES)-1:0]   control_state,
  output logic                                reg_file_en,
  output logic                                reg_file_rw,
  output logic [ADDR_WIDTH-1:0]               reg_sel,
  output logic [DATA_WIDTH-1:0]               reg_wr_data,
  input  logic [DATA_WIDTH-1:0]               reg_rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [DATA_WIDTH-1:0]               acc,
  output logic                                flag_z,
  output logic                                flag_c,
  output logic                                addr_err,
  output logic                                busy
);

  localparam int CsW = $clog2(CONTROL_STATES);
  localparam logic [CsW-1:0] CS_DEC = CsW'(DECODE);
  localparam logic [CsW-1:0] CS_EX1 = CsW'(EXECUTE1);
  localparam logic [CsW-1:0] CS_EX2 = CsW'(EXECUTE2);
  localparam logic RW_RD = 1'(REG_FILE_READ);
  localparam logic RW_WR = 1'(REG_FILE_WRITE);

  typedef enum logic [2:0] {
    S_FETCH, S_DEC, S_EXEC1, S_EXEC2, S_WB, S_OUTW
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_LDI = 3'b001, OP_LD  = 3'b010, OP_ST  = 3'b011,
    OP_ADD = 3'b100, OP_SUB = 3'b101, OP_AND = 3'b110, OP_OUT = 3'b111
  } op_t;

  state_t                  state_q;
  op_t                     op_q;
  logic [ADDR_WIDTH-1:0]   opnd_q;
  logic [DATA_WIDTH-1:0]   acc_q, od_q;
  logic                    z_q, c_q, err_q, en_q, rw_q, ov_q;
  logic [CsW-1:0]          cs_q;

  logic [DATA_WIDTH:0]     sum_d;
  logic [DATA_WIDTH-1:0]   alu_acc_d, ldi_acc_d;
  logic                    alu_c_d, addr_bad_d;

  assign addr_bad_d = 32'(opnd_q) >= 32'(DEPTH);
  assign ldi_acc_d  = DATA_WIDTH'(opnd_q);

  always_comb begin
    sum_d     = {1'b0, acc_q} + {1'b0, reg_rd_data};
    alu_acc_d = acc_q;
    alu_c_d   = c_q;
    case (op_q)
      OP_LD:  alu_acc_d = reg_rd_data;
      OP_ADD: {alu_c_d, alu_acc_d} = sum_d;
      OP_SUB: begin
        alu_acc_d = acc_q - reg_rd_data;
        alu_c_d   = acc_q < reg_rd_data;
      end
      OP_AND: begin
        alu_acc_d = acc_q & reg_rd_data;
        alu_c_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= S_FETCH;
      op_q    <= OP_NOP;
      opnd_q  <= '0;
      acc_q   <= '0;
      od_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= RW_RD;
      cs_q    <= CS_DEC;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            op_q    <= op_t'(instr[ADDR_WIDTH+2:ADDR_WIDTH]);
            opnd_q  <= instr[ADDR_WIDTH-1:0];
            state_q <= S_DEC;
          end
        end
        S_DEC: begin
          case (op_q)
            OP_NOP: state_q <= S_FETCH;
            OP_LDI: begin
              acc_q   <= ldi_acc_d;
              z_q     <= (ldi_acc_d == '0);
              state_q <= S_FETCH;
            end
            OP_OUT: begin
              od_q    <= acc_q;
              ov_q    <= 1'b1;
              state_q <= S_OUTW;
            end
            default: begin
              if (addr_bad_d) begin
                err_q   <= 1'b1;
                state_q <= S_FETCH;
              end else begin
                en_q    <= 1'b1;
                cs_q    <= CS_EX1;
                rw_q    <= (op_q == OP_ST) ? RW_WR : RW_RD;
                state_q <= S_EXEC1;
              end
            end
          endcase
        end
        S_EXEC1: begin
          cs_q    <= CS_EX2;
          state_q <= S_EXEC2;
        end
        S_EXEC2: begin
          en_q    <= 1'b0;
          cs_q    <= CS_DEC;
          rw_q    <= RW_RD;
          state_q <= (op_q == OP_ST) ? S_FETCH : S_WB;
        end
        S_WB: begin
          acc_q   <= alu_acc_d;
          c_q     <= alu_c_d;
          z_q     <= (alu_acc_d == '0);
          state_q <= S_FETCH;
        end
        S_OUTW: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign instr_ready   = (state_q == S_FETCH);
  assign busy          = (state_q != S_FETCH);
  assign control_state = cs_q;
  assign reg_file_en   = en_q;
  assign reg_file_rw   = rw_q;
  assign reg_sel       = opnd_q;
  assign reg_wr_data   = acc_q;
  assign out_valid     = ov_q;
  assign out_data      = od_q;
  assign acc           = acc_q;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
  assign addr_err      = err_q;

endmodule

// File: tb/tb_ucpu_control_unit.sv
// Directed bench for ucpu_control_unit with a behavioural 32-word data memory.
module tb_ucpu_control_unit;
  logic       sys_clk = 1'b0;
  logic       sys_reset, instr_valid, out_ready;
  logic [7:0] instr, reg_rd_data;
  logic       instr_ready, reg_file_en, reg_file_rw, out_valid;
  logic       flag_z, flag_c, addr_err, busy;
  logic [1:0] control_state;
  logic [4:0] reg_sel;
  logic [7:0] reg_wr_data, out_data, acc;

  ucpu_control_unit dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .control_state(control_state),
    .reg_file_en(reg_file_en), .reg_file_rw(reg_file_rw), .reg_sel(reg_sel),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc(acc), .flag_z(flag_z),
    .flag_c(flag_c), .addr_err(addr_err), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] mem [32];
  always @(posedge sys_clk) begin
    if (reg_file_en && control_state == 2'd2) begin
      if (reg_file_rw) mem[reg_sel] <= reg_wr_data;
      else             reg_rd_data  <= mem[reg_sel];
    end
  end

  int tests = 0, fails = 0;
  int lat, en_cnt, en_first, ov_cnt, od_chg, stall;
  logic rw_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one instruction and runs until instr_ready returns (cycle count in lat).
  task automatic exec(input logic [7:0] ins);
    int n;
    logic [7:0] od0;
    od0 = 8'h00;
    en_cnt = 0; en_first = 0; ov_cnt = 0; od_chg = 0; rw_seen = 1'b0;
    out_ready = (stall == 0);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge sys_clk); #1;
    instr_valid = 1'b0;
    n = 1;
    while (n <= 40) begin
      if (reg_file_en) begin
        if (en_cnt == 0) en_first = n;
        en_cnt++;
        rw_seen = reg_file_rw;
      end
      if (out_valid) begin
        if (ov_cnt == 0) od0 = out_data;
        else if (out_data !== od0) od_chg++;
        ov_cnt++;
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
        end
      end
      if (instr_ready) break;
      @(posedge sys_clk); #1;
      n++;
    end
    lat = n;
  endtask

  logic [7:0] exp_acc;
  logic [8:0] s9;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hAA;
    sys_reset = 1'b0; instr_valid = 1'b0; instr = 8'h00; out_ready = 1'b1; stall = 0;
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, 0);
    chk("rst_cs", control_state, 0);
    chk("rst_en", reg_file_en, 0);
    chk("rst_rw", reg_file_rw, 0);
    chk("rst_sel", reg_sel, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_flags", {flag_z, flag_c, addr_err}, 0);
    @(negedge sys_clk); sys_reset = 1'b1;
    @(posedge sys_clk); #1;

    exec(8'h25);
    chk("ldi5_lat", lat, 2);
    chk("ldi5_acc", acc, 8'h05);
    exec(8'hE0);
    chk("out_lat", lat, 3);
    chk("out_vcnt", ov_cnt, 1);
    chk("out_data", out_data, 8'h05);
    chk("out_z", flag_z, 0);
    chk("out_vlow", out_valid, 0);

    exec(8'h3F);
    exec(8'h63);
    chk("st_lat", lat, 4);
    chk("st_encnt", en_cnt, 2);
    chk("st_enfirst", en_first, 2);
    chk("st_rw", rw_seen, 1);
    chk("st_mem3", mem[3], 8'h1F);
    exec(8'h20);
    chk("ldi0_z", flag_z, 1);
    exec(8'h43);
    chk("ld_lat", lat, 5);
    chk("ld_encnt", en_cnt, 2);
    chk("ld_enfirst", en_first, 2);
    chk("ld_rw", rw_seen, 0);
    chk("ld_acc", acc, 8'h1F);
    chk("ld_z", flag_z, 0);

    exec(8'h3F);
    exec(8'h60);
    exp_acc = 8'd31;
    for (int k = 0; k < 8; k++) begin
      exec(8'h80);
      s9 = {1'b0, exp_acc} + 9'd31;
      exp_acc = s9[7:0];
      chk("add_lat", lat, 5);
      chk("add_acc", acc, exp_acc);
      chk("add_c", flag_c, s9[8]);
    end
    chk("add_wrap", acc, 8'h17);

    exec(8'h20);
    exec(8'h62);
    exec(8'h21);
    exec(8'h61);
    exec(8'h20);
    exec(8'hA1);
    chk("sub_acc", acc, 8'hFF);
    chk("sub_c", flag_c, 1);
    chk("sub_z", flag_z, 0);
    exec(8'hC2);
    chk("and_acc", acc, 8'h00);
    chk("and_z", flag_z, 1);
    chk("and_c", flag_c, 0);

    exec(8'h27);
    exec(8'h54);
    chk("ill_lat", lat, 2);
    chk("ill_en", en_cnt, 0);
    chk("ill_err", addr_err, 1);
    chk("ill_acc", acc, 8'h07);

    exec(8'h29);
    chk("abort_ready", instr_ready, 1);
    instr_valid = 1'b1; instr = 8'h65;
    @(posedge sys_clk); #1;
    instr_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("abort_en_pre", reg_file_en, 1);
    chk("abort_cs_pre", control_state, 1);
    sys_reset = 1'b0;
    #1;
    chk("abort_en", reg_file_en, 0);
    chk("abort_cs", control_state, 0);
    chk("abort_ready_rst", instr_ready, 1);
    chk("abort_acc", acc, 0);
    chk("abort_err", addr_err, 0);
    @(posedge sys_clk); @(posedge sys_clk);
    @(negedge sys_clk); sys_reset = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort_mem5", mem[5], 8'hAA);

    exec(8'h2C);
    stall = 4;
    exec(8'hE0);
    chk("stall_lat", lat, 7);
    chk("stall_vcnt", ov_cnt, 5);
    chk("stall_stable", od_chg, 0);
    chk("stall_data", out_data, 8'h0C);
    chk("stall_vlow", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
